spc700_ram_arbiter: RTL and testbench
=====================================

# spc700_ram_arbiter

Two-requester arbiter that shares the single read/write port of the 64 KiB SPC700 audio RAM between the DSP voice engine (reads only: sample directory and BRR fetches) and the SPC700 CPU core (reads and writes). It sits between both masters and the RAM's APU port and issues at most one RAM access per clock. The DSP has fixed priority, and a streak counter bounds how long the CPU can be starved. The RAM read data is registered, so read data returns one cycle after grant.

## Interface
- ADDRESS_BITS, 16: width of every address bus.
- DSP_STREAK_MAX, 4: maximum consecutive contested DSP grants before the CPU is forced one slot; legal range 1–15.

- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_dsp_req  in  1  DSP access request; held with its address until acked.
- in_dsp_address  in  ADDRESS_BITS  DSP read address.
- out_dsp_ack  out  1  combinational; the DSP request is granted this cycle.
- out_dsp_valid  out  1  registered; DSP read data is present this cycle.
- out_dsp_data  out  8  DSP read data.
- in_cpu_req  in  1  CPU access request; held with address, we and data until acked.
- in_cpu_we  in  1  1 = write, 0 = read.
- in_cpu_address  in  ADDRESS_BITS  CPU address.
- in_cpu_data  in  8  CPU write data.
- out_cpu_ack  out  1  combinational; the CPU request is granted this cycle.
- out_cpu_valid  out  1  registered; CPU read data is present this cycle. Never asserted for writes.
- out_cpu_data  out  8  CPU read data.
- out_ram_address  out  ADDRESS_BITS  to the RAM APU port address.
- out_ram_data  out  8  to the RAM APU port write data.
- out_ram_we  out  1  to the RAM APU port write enable.
- in_ram_data  in  8  RAM APU port read data; registered in the RAM, valid 1 cycle after the address is presented.

## Operation
- Grant decision each cycle, combinational on the requests and the streak counter:
  - Neither request: no grant; out_ram_we = 0; out_ram_address = 0.
  - Only one request: grant that requester.
  - Both requests, streak < DSP_STREAK_MAX: grant DSP.
  - Both requests, streak == DSP_STREAK_MAX: grant CPU.
- Granting drives the RAM port from the winner:
  - DSP granted: out_ram_address = in_dsp_address; out_ram_we = 0.
  - CPU granted: out_ram_address = in_cpu_address; out_ram_data = in_cpu_data; out_ram_we = in_cpu_we.
  - When no write is in progress, out_ram_data = 0.
- Streak counter, 4 bits:
  - Increments, saturating at DSP_STREAK_MAX, on a DSP grant while in_cpu_req = 1.
  - Clears to 0 on any CPU grant.
  - Clears to 0 on any cycle with in_cpu_req = 0.
- Pending-return register: two bits, dsp_rd and cpu_rd. Each is set on the edge after a read grant to that requester; they drive the matching valid outputs.
- Data outputs:
  - In a valid cycle, out_x_data equals in_ram_data.
  - Otherwise out_x_data holds the value from the last valid cycle of that requester. One 8-bit hold register per requester.
- No ordering hazard: a CPU write granted in cycle N is committed at the end of N, so any read granted in N+1 or later returns the new value.

## Timing
- Reset (synchronous): streak = 0, both valid = 0, both hold registers = 0.
  - In the reset cycle itself, ack and we outputs are forced to 0 and no RAM access is issued.
  - A read granted the cycle before reset asserts produces no valid pulse.
- Read latency: ack in cycle N, then valid and data in cycle N+1. Back-to-back grants give one access per cycle, 100% port utilisation.
- Write: ack in cycle N with out_ram_we = 1 in N. No response cycle follows.
- A requester may change its address or drop its request only in the cycle after its ack.
- While any requester is active, ack asserts on exactly one of the two in every cycle.
- Worst-case CPU wait under continuous DSP load: DSP_STREAK_MAX cycles.

## Test plan
- Write then read back: after reset, CPU writes 0xA5 to 0x1234 (ack in cycle 0, out_ram_we = 1) and reads 0x1234 in cycle 1. Required: out_cpu_valid = 1 with data 0xA5 in cycle 2, and out_cpu_data still 0xA5 in cycle 5.
- DSP burst: DSP reads 0x2000–0x2007 back-to-back with the CPU idle. Required: acks in cycles 0–7, valids in cycles 1–8, data in address order, streak stays 0.
- Starvation guard: DSP and CPU both request continuously with DSP_STREAK_MAX = 4. Required: grants repeat the pattern D D D D C, and the CPU's first ack lands in cycle 4.
- Simultaneous write/read race: CPU writes 0x3C to 0x0100 and DSP reads 0x0100, both requested in the same cycle. Required: DSP granted first and returns the old value. With a fresh streak, the CPU write completes in the next cycle, and a second DSP read then returns 0x3C.
- Reset mid-operation: DSP read granted in cycle N, reset asserted in N+1. Required: out_dsp_valid = 0 in N+1 and N+2, no acks during reset, out_dsp_data = 0 after reset.
- Idle bus: no requests for 10 cycles. Required: out_ram_we = 0, both acks = 0, both valids = 0 throughout.

Source files
------------

// File: rtl/spc700_ram_arbiter.sv
// ============================================================================
// spc700_ram_arbiter
//
// Purpose
//   Shares the single read/write APU port of the 64 KiB SPC700 audio RAM
//   between two masters:
//     - the DSP voice engine (reads only: sample directory and BRR fetches)
//     - the SPC700 CPU core (reads and writes)
//   At most one RAM access is issued per clock. The DSP has fixed priority.
//   A saturating streak counter tracks how many contested DSP grants have
//   been given in a row. Once it reaches DSP_STREAK_MAX, the CPU is forced
//   one slot. The RAM read data is registered inside the RAM, so read data
//   returns one cycle after the grant.
//
// Handshake (both masters)
//   A master raises in_x_req with its address (and for the CPU, we/data) and
//   holds them stable until out_x_ack is high in the same cycle. out_x_ack is
//   combinational and means "the access is issued to the RAM this cycle". The
//   master may change its address or drop its request only in the cycle after
//   the ack. A read acked in cycle N returns out_x_valid = 1 with out_x_data in
//   cycle N+1. A write acked in cycle N is committed at the end of N and has
//   no response cycle.
//
// Parameters
//   ADDRESS_BITS    width of every address bus (16 for the SPC700 RAM)
//   DSP_STREAK_MAX  contested DSP grants allowed before the CPU gets a slot
//                   (legal range 1..15; the streak counter is 4 bits)
//
// Ports
//   clock            system clock, all state updates on the rising edge
//   reset            synchronous active-high reset
//   in_dsp_req       DSP request
//   in_dsp_address   DSP read address
//   out_dsp_ack      DSP granted this cycle (combinational)
//   out_dsp_valid    DSP read data present this cycle
//   out_dsp_data     DSP read data (holds the last returned value)
//   in_cpu_req       CPU request
//   in_cpu_we        CPU access type, 1 = write, 0 = read
//   in_cpu_address   CPU address
//   in_cpu_data      CPU write data
//   out_cpu_ack      CPU granted this cycle (combinational)
//   out_cpu_valid    CPU read data present this cycle (never for writes)
//   out_cpu_data     CPU read data (holds the last returned value)
//   out_ram_address  RAM APU port address
//   out_ram_data     RAM APU port write data (0 unless a write is issued)
//   out_ram_we       RAM APU port write enable
//   in_ram_data      RAM APU port read data, valid one cycle after address
// ============================================================================
module spc700_ram_arbiter #(
    parameter int ADDRESS_BITS   = 16,
    parameter int DSP_STREAK_MAX = 4
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    in_dsp_req,
    input  logic [ADDRESS_BITS-1:0] in_dsp_address,
    output logic                    out_dsp_ack,
    output logic                    out_dsp_valid,
    output logic [7:0]              out_dsp_data,

    input  logic                    in_cpu_req,
    input  logic                    in_cpu_we,
    input  logic [ADDRESS_BITS-1:0] in_cpu_address,
    input  logic [7:0]              in_cpu_data,
    output logic                    out_cpu_ack,
    output logic                    out_cpu_valid,
    output logic [7:0]              out_cpu_data,

    output logic [ADDRESS_BITS-1:0] out_ram_address,
    output logic [7:0]              out_ram_data,
    output logic                    out_ram_we,
    input  logic [7:0]              in_ram_data
);

    // Threshold in the counter's own width so the compare is width-matched.
    localparam logic [3:0] STREAK_MAX = 4'(DSP_STREAK_MAX);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [3:0] r_streak;      // consecutive contested DSP grants
    logic       r_dsp_rd;      // pending-return: DSP read granted last cycle
    logic       r_cpu_rd;      // pending-return: CPU read granted last cycle
    logic [7:0] r_dsp_hold;    // last data returned to the DSP
    logic [7:0] r_cpu_hold;    // last data returned to the CPU

    // ------------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------------
    logic w_cpu_turn;          // streak has reached the limit
    logic w_dsp_grant;
    logic w_cpu_grant;
    logic w_dsp_valid;
    logic w_cpu_valid;

    // The CPU only loses a cycle when the DSP is also asking and the streak
    // has not yet reached the limit. Reset suppresses every grant so that no
    // RAM access is issued in the reset cycle itself.
    assign w_cpu_turn  = (r_streak >= STREAK_MAX);
    assign w_dsp_grant = !reset && in_dsp_req && !(in_cpu_req && w_cpu_turn);
    assign w_cpu_grant = !reset && in_cpu_req && !(in_dsp_req && !w_cpu_turn);

    assign out_dsp_ack = w_dsp_grant;
    assign out_cpu_ack = w_cpu_grant;

    // ------------------------------------------------------------------------
    // RAM port drive
    // ------------------------------------------------------------------------
    always_comb begin
        out_ram_address = '0;
        out_ram_data    = 8'h00;
        out_ram_we      = 1'b0;
        if (w_dsp_grant) begin
            out_ram_address = in_dsp_address;
        end else if (w_cpu_grant) begin
            out_ram_address = in_cpu_address;
            out_ram_we      = in_cpu_we;
            // Write data is only presented while a write is actually issued.
            if (in_cpu_we) begin
                out_ram_data = in_cpu_data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Streak counter
    // ------------------------------------------------------------------------
    // Counts only contested DSP grants: any cycle without a CPU request, or
    // any CPU grant, starts the count over. Saturates at the limit so the CPU
    // keeps its claim on the next slot until it is actually served.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_streak <= 4'd0;
        end else if (!in_cpu_req || w_cpu_grant) begin
            r_streak <= 4'd0;
        end else if (w_dsp_grant && (r_streak < STREAK_MAX)) begin
            r_streak <= r_streak + 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Pending-return register
    // ------------------------------------------------------------------------
    // Set on the edge after a read grant. CPU writes never produce a return.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dsp_rd <= 1'b0;
            r_cpu_rd <= 1'b0;
        end else begin
            r_dsp_rd <= w_dsp_grant;
            r_cpu_rd <= w_cpu_grant && !in_cpu_we;
        end
    end

    // A read granted in the cycle just before reset has its pending bit set
    // during the reset cycle; masking with reset drops that return so the
    // master never sees a valid from an access issued before the reset.
    assign w_dsp_valid = r_dsp_rd && !reset;
    assign w_cpu_valid = r_cpu_rd && !reset;

    assign out_dsp_valid = w_dsp_valid;
    assign out_cpu_valid = w_cpu_valid;

    // ------------------------------------------------------------------------
    // Data return and hold
    // ------------------------------------------------------------------------
    // In a valid cycle the RAM data passes straight through; the hold
    // register captures it so the output stays stable until the next return.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dsp_hold <= 8'h00;
            r_cpu_hold <= 8'h00;
        end else begin
            if (w_dsp_valid) begin
                r_dsp_hold <= in_ram_data;
            end
            if (w_cpu_valid) begin
                r_cpu_hold <= in_ram_data;
            end
        end
    end

    assign out_dsp_data = w_dsp_valid ? in_ram_data : r_dsp_hold;
    assign out_cpu_data = w_cpu_valid ? in_ram_data : r_cpu_hold;

endmodule

// File: tb/tb_spc700_ram_arbiter.sv
// ============================================================================
// tb_spc700_ram_arbiter
//
// Directed bench for spc700_ram_arbiter. A behavioural 64 KiB RAM with a
// registered read port sits on the RAM side. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge of the same cycle.
// ============================================================================
module tb_spc700_ram_arbiter;

    localparam int AW = 16;

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    logic clock;
    logic reset;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ------------------------------------------------------------------------
    // DUT
    // ------------------------------------------------------------------------
    logic          in_dsp_req;
    logic [AW-1:0] in_dsp_address;
    logic          out_dsp_ack;
    logic          out_dsp_valid;
    logic [7:0]    out_dsp_data;
    logic          in_cpu_req;
    logic          in_cpu_we;
    logic [AW-1:0] in_cpu_address;
    logic [7:0]    in_cpu_data;
    logic          out_cpu_ack;
    logic          out_cpu_valid;
    logic [7:0]    out_cpu_data;
    logic [AW-1:0] out_ram_address;
    logic [7:0]    out_ram_data;
    logic          out_ram_we;
    logic [7:0]    in_ram_data;

    spc700_ram_arbiter #(
        .ADDRESS_BITS   (AW),
        .DSP_STREAK_MAX (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in_dsp_req      (in_dsp_req),
        .in_dsp_address  (in_dsp_address),
        .out_dsp_ack     (out_dsp_ack),
        .out_dsp_valid   (out_dsp_valid),
        .out_dsp_data    (out_dsp_data),
        .in_cpu_req      (in_cpu_req),
        .in_cpu_we       (in_cpu_we),
        .in_cpu_address  (in_cpu_address),
        .in_cpu_data     (in_cpu_data),
        .out_cpu_ack     (out_cpu_ack),
        .out_cpu_valid   (out_cpu_valid),
        .out_cpu_data    (out_cpu_data),
        .out_ram_address (out_ram_address),
        .out_ram_data    (out_ram_data),
        .out_ram_we      (out_ram_we),
        .in_ram_data     (in_ram_data)
    );

    // ------------------------------------------------------------------------
    // RAM model: synchronous write, registered read
    // ------------------------------------------------------------------------
    logic [7:0] mem [0:65535];

    always @(posedge clock) begin
        if (out_ram_we) begin
            mem[out_ram_address] <= out_ram_data;
        end
        in_ram_data <= mem[out_ram_address];
    end

    // ------------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------------
    int n_pass;
    int n_total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start of the next cycle (inputs may change here).
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Sampling point inside the current cycle.
    task automatic sample();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        in_dsp_req     = 1'b0;
        in_dsp_address = '0;
        in_cpu_req     = 1'b0;
        in_cpu_we      = 1'b0;
        in_cpu_address = '0;
        in_cpu_data    = 8'h00;
    endtask

    // One uncontested CPU write; caller is at the start of a cycle.
    task automatic cpu_write(input logic [AW-1:0] addr, input logic [7:0] data);
        in_cpu_req     = 1'b1;
        in_cpu_we      = 1'b1;
        in_cpu_address = addr;
        in_cpu_data    = data;
        sample();
        chk("preload_ack", {31'd0, out_cpu_ack}, 32'd1);
        next_cycle();
        idle_inputs();
    endtask

    logic [9:0] starve_pattern;

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        idle_inputs();

        // ---- Reset cycle with both masters requesting: nothing is granted.
        next_cycle();
        in_dsp_req     = 1'b1;
        in_cpu_req     = 1'b1;
        in_cpu_we      = 1'b1;
        in_cpu_address = 16'h0055;
        in_cpu_data    = 8'hFF;
        sample();
        chk("rst_dsp_ack", {31'd0, out_dsp_ack}, 32'd0);
        chk("rst_cpu_ack", {31'd0, out_cpu_ack}, 32'd0);
        chk("rst_ram_we",  {31'd0, out_ram_we},  32'd0);

        next_cycle();
        reset = 1'b0;
        idle_inputs();
        sample();
        chk("post_rst_dsp_valid", {31'd0, out_dsp_valid}, 32'd0);
        chk("post_rst_cpu_valid", {31'd0, out_cpu_valid}, 32'd0);
        chk("post_rst_dsp_data",  {24'd0, out_dsp_data},  32'h00);
        chk("post_rst_cpu_data",  {24'd0, out_cpu_data},  32'h00);
        chk("post_rst_streak",    {28'd0, dut.r_streak},  32'd0);

        // ---- Write then read back
        next_cycle();                          // cycle 0: write A5 -> 1234
        in_cpu_req     = 1'b1;
        in_cpu_we      = 1'b1;
        in_cpu_address = 16'h1234;
        in_cpu_data    = 8'hA5;
        sample();
        chk("wr_cpu_ack",  {31'd0, out_cpu_ack},    32'd1);
        chk("wr_dsp_ack",  {31'd0, out_dsp_ack},    32'd0);
        chk("wr_ram_we",   {31'd0, out_ram_we},     32'd1);
        chk("wr_ram_addr", {16'd0, out_ram_address}, 32'h1234);
        chk("wr_ram_data", {24'd0, out_ram_data},   32'hA5);

        next_cycle();                          // cycle 1: read 1234
        in_cpu_we   = 1'b0;
        in_cpu_data = 8'h00;
        sample();
        chk("rd_cpu_ack",      {31'd0, out_cpu_ack},   32'd1);
        chk("rd_ram_we",       {31'd0, out_ram_we},    32'd0);
        chk("rd_ram_data",     {24'd0, out_ram_data},  32'h00);
        chk("wr_no_cpu_valid", {31'd0, out_cpu_valid}, 32'd0);

        next_cycle();                          // cycle 2: data returns
        idle_inputs();
        sample();
        chk("rd_cpu_valid", {31'd0, out_cpu_valid}, 32'd1);
        chk("rd_cpu_data",  {24'd0, out_cpu_data},  32'hA5);

        next_cycle();                          // cycle 3
        next_cycle();                          // cycle 4
        next_cycle();                          // cycle 5: data held
        sample();
        chk("hold_cpu_valid", {31'd0, out_cpu_valid}, 32'd0);
        chk("hold_cpu_data",  {24'd0, out_cpu_data},  32'hA5);

        // ---- Preload RAM through the arbiter for the following steps
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            cpu_write(16'h2000 + 16'(i), 8'h40 + 8'(i));
        end
        cpu_write(16'h0100, 8'h77);

        // ---- DSP burst 0x2000..0x2007 with the CPU idle
        for (int i = 0; i < 8; i++) begin
            in_dsp_req     = 1'b1;
            in_dsp_address = 16'h2000 + 16'(i);
            sample();
            chk("burst_dsp_ack",  {31'd0, out_dsp_ack},     32'd1);
            chk("burst_ram_addr", {16'd0, out_ram_address}, 32'h2000 + i);
            if (i > 0) begin
                chk("burst_dsp_valid", {31'd0, out_dsp_valid}, 32'd1);
                chk("burst_dsp_data",  {24'd0, out_dsp_data},  32'h40 + i - 1);
            end
            chk("burst_streak", {28'd0, dut.r_streak}, 32'd0);
            next_cycle();
        end
        idle_inputs();                         // cycle 8: last return
        sample();
        chk("burst_last_valid", {31'd0, out_dsp_valid}, 32'd1);
        chk("burst_last_data",  {24'd0, out_dsp_data},  32'h47);
        chk("burst_end_streak", {28'd0, dut.r_streak},  32'd0);

        // ---- Starvation guard: both request continuously
        // Expected CPU grants, cycle 0 in bit 0: D D D D C D D D D C
        starve_pattern = 10'b10000_10000;
        next_cycle();
        in_dsp_req     = 1'b1;
        in_dsp_address = 16'h2000;
        in_cpu_req     = 1'b1;
        in_cpu_we      = 1'b0;
        in_cpu_address = 16'h2001;
        for (int k = 0; k < 10; k++) begin
            sample();
            chk("starve_cpu_ack", {31'd0, out_cpu_ack}, {31'd0, starve_pattern[k]});
            chk("starve_dsp_ack", {31'd0, out_dsp_ack}, {31'd0, !starve_pattern[k]});
            next_cycle();
        end
        idle_inputs();                         // CPU read from cycle 9 returns
        sample();
        chk("starve_cpu_valid", {31'd0, out_cpu_valid}, 32'd1);
        chk("starve_cpu_data",  {24'd0, out_cpu_data},  32'h41);

        // ---- Simultaneous write/read race on 0x0100
        next_cycle();                          // cycle 0: both request
        in_dsp_req     = 1'b1;
        in_dsp_address = 16'h0100;
        in_cpu_req     = 1'b1;
        in_cpu_we      = 1'b1;
        in_cpu_address = 16'h0100;
        in_cpu_data    = 8'h3C;
        sample();
        chk("race_dsp_ack", {31'd0, out_dsp_ack}, 32'd1);
        chk("race_cpu_ack", {31'd0, out_cpu_ack}, 32'd0);
        chk("race_ram_we0", {31'd0, out_ram_we},  32'd0);

        next_cycle();                          // cycle 1: CPU write goes
        in_dsp_req = 1'b0;
        sample();
        chk("race_cpu_ack1",  {31'd0, out_cpu_ack},  32'd1);
        chk("race_ram_we1",   {31'd0, out_ram_we},   32'd1);
        chk("race_ram_data1", {24'd0, out_ram_data}, 32'h3C);
        chk("race_old_valid", {31'd0, out_dsp_valid}, 32'd1);
        chk("race_old_data",  {24'd0, out_dsp_data},  32'h77);

        next_cycle();                          // cycle 2: DSP reads again
        in_cpu_req     = 1'b0;
        in_cpu_we      = 1'b0;
        in_cpu_data    = 8'h00;
        in_dsp_req     = 1'b1;
        sample();
        chk("race_dsp_ack2", {31'd0, out_dsp_ack}, 32'd1);

        next_cycle();                          // cycle 3: new value
        idle_inputs();
        sample();
        chk("race_new_valid", {31'd0, out_dsp_valid}, 32'd1);
        chk("race_new_data",  {24'd0, out_dsp_data},  32'h3C);

        // ---- Reset mid-operation
        next_cycle();                          // cycle N: DSP read granted
        in_dsp_req     = 1'b1;
        in_dsp_address = 16'h2003;
        sample();
        chk("midrst_ack_n", {31'd0, out_dsp_ack}, 32'd1);

        next_cycle();                          // cycle N+1: reset
        reset      = 1'b1;
        in_cpu_req = 1'b1;
        sample();
        chk("midrst_valid_n1",   {31'd0, out_dsp_valid}, 32'd0);
        chk("midrst_dsp_ack_n1", {31'd0, out_dsp_ack},   32'd0);
        chk("midrst_cpu_ack_n1", {31'd0, out_cpu_ack},   32'd0);
        chk("midrst_ram_we_n1",  {31'd0, out_ram_we},    32'd0);

        next_cycle();                          // cycle N+2: out of reset
        reset = 1'b0;
        idle_inputs();
        sample();
        chk("midrst_valid_n2", {31'd0, out_dsp_valid}, 32'd0);
        chk("midrst_dsp_data", {24'd0, out_dsp_data},  32'h00);
        chk("midrst_cpu_data", {24'd0, out_cpu_data},  32'h00);

        // ---- Idle bus for 10 cycles
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            sample();
            chk("idle_ram_we",    {31'd0, out_ram_we},      32'd0);
            chk("idle_ram_addr",  {16'd0, out_ram_address}, 32'h0);
            chk("idle_dsp_ack",   {31'd0, out_dsp_ack},     32'd0);
            chk("idle_cpu_ack",   {31'd0, out_cpu_ack},     32'd0);
            chk("idle_dsp_valid", {31'd0, out_dsp_valid},   32'd0);
            chk("idle_cpu_valid", {31'd0, out_cpu_valid},   32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
